sub_serial: RTL and testbench

SUB_SERIAL -- requirements
Module: sub_serial

---
 rtl/sub_serial.sv | 66 ++++++
 tb/tb_sub_serial.sv | 91 +++++++++
 2 files changed

// File: rtl/sub_serial.sv
// sub_serial: bit-serial WIDTH-bit subtractor, one bit per cycle LSB first.
// Define SUB_SERIAL_SAT_EN to clamp a borrowing result to zero.
module sub_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, out_next;
  logic [CW-1:0] count;
  logic borrow, d, borrow_next, last;
  assign d = a_reg[0] ^ b_reg[0] ^ borrow;
  assign borrow_next = (~a_reg[0] & b_reg[0]) | (~a_reg[0] & borrow) | (b_reg[0] & borrow);
  assign last = (state == SUB) && (count == LAST);
`ifdef SUB_SERIAL_SAT_EN
  assign out_next = (last && borrow_next) ? '0 : {d, out[WIDTH-1:1]};
`else
  assign out_next = {d, out[WIDTH-1:1]};
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_next;
  always_comb
    state_next = (state == IDLE) ? (en ? SUB : IDLE) :
                 (state == SUB)  ? (count == LAST ? DONE : SUB) :
                 (state == DONE && en) ? DONE : IDLE;
  always_comb begin
    busy = state == SUB;
    done = state == DONE;
  end
  // count saturates at LAST so it never wraps on power-of-two widths
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      out <= '0;
      borrow <= 1'b0;
      count <= '0;
      borrow_out <= 1'b0;
    end else if (state == IDLE && en) begin
      a_reg <= a;
      b_reg <= b;
      out <= '0;
      borrow <= 1'b0;
      count <= '0;
      borrow_out <= 1'b0;
    end else if (state == SUB) begin
      a_reg <= a_reg >> 1;
      b_reg <= b_reg >> 1;
      out <= out_next;
      borrow <= borrow_next;
      if (!last) count <= count + 1'b1;
      if (last) borrow_out <= borrow_next;
    end
endmodule

// File: tb/tb_sub_serial.sv
// tb_sub_serial: directed checks of sub_serial at WIDTH=8.
module tb_sub_serial;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [7:0] a = '0, b = '0, out;
  logic borrow_out, busy, done;
  int vectors = 0, errs = 0;

  sub_serial #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .en(en), .a(a), .b(b),
    .out(out), .borrow_out(borrow_out), .busy(busy), .done(done));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s: got %0d expected %0d", tag, o, e);
    end
  endtask

  task automatic run(input logic [7:0] x, input logic [7:0] y, input logic [7:0] eo,
                     input logic eb, input int hold);
    @(negedge clk);
    a = x; b = y; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("busy", {busy, done}, 2'b10);
      a = 8'($urandom);
      b = 8'($urandom);
      en = 1'($urandom);
      @(negedge clk);
    end
    en = hold > 0;
    check("done", {busy, done}, 2'b01);
    check("out", out, eo);
    check("borrow_out", borrow_out, eb);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_done", done, 1'b1);
      check("hold_out", {borrow_out, out}, {eb, eo});
    end
    en = 1'b0;
    @(negedge clk);
    check("idle", {busy, done}, 2'b00);
    check("retain", {borrow_out, out}, {eb, eo});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset", {busy, done, borrow_out, out}, 11'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_en", {busy, done}, 2'b00);
    run(8'd9, 8'd3, 8'd6, 1'b0, 0);
`ifdef SUB_SERIAL_SAT_EN
    run(8'd3, 8'd9, 8'd0, 1'b1, 0);
`else
    run(8'd3, 8'd9, 8'd250, 1'b1, 0);
`endif
    run(8'd255, 8'd255, 8'd0, 1'b0, 0);
    run(8'd0, 8'd0, 8'd0, 1'b0, 0);
`ifdef SUB_SERIAL_SAT_EN
    run(8'd0, 8'd1, 8'd0, 1'b1, 0);
`else
    run(8'd0, 8'd1, 8'd255, 1'b1, 0);
`endif
    @(negedge clk);
    a = 8'd9; b = 8'd3; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1 check("async_rst", {busy, done, borrow_out, out}, 11'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {busy, done, borrow_out, out}, 11'd0);
    run(8'd100, 8'd58, 8'd42, 1'b0, 5);
    run(8'd200, 8'd45, 8'd155, 1'b0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
